ov7670_frame_writer: RTL and testbench
======================================

Name: ov7670_frame_writer

Overview:
Write-side counterpart to the VGA read-address path. Captures the OV7670 RGB565 byte stream, decimates the 640x480 source to a 160x120 image, and issues frame-buffer write strobes with a linear address (row*IMAGE_SIZE_H + col) and 12-bit RGB444 data. The block sits between the camera pins and the write port of the dual-port frame RAM whose read port the VGA side drives.

Parameters:
IMAGE_SIZE_H, 160, stored pixels per line
IMAGE_SIZE_V, 120, stored lines per frame
SRC_H, 640, source pixels per href line
SRC_V, 480, source href lines per frame
SCALE_SHIFT, 2, decimation factor 2^SCALE_SHIFT applied in both axes

Ports:
clk  input  1  camera pixel clock (pclk); the only clock
rst_n  input  1  asynchronous active-low reset
vsync  input  1  camera vsync; high = vertical blanking
href  input  1  camera href; high = valid bytes on din
din  input  8  camera data byte
we  output  1  frame-RAM write enable, one cycle per stored pixel
waddr  output  16  frame-RAM write address, 0..IMAGE_SIZE_H*IMAGE_SIZE_V-1
wdata  output  12  pixel data {R[3:0],G[3:0],B[3:0]}
frame_done  output  1  one-cycle pulse at the end of each captured frame
busy  output  1  high while in CAPTURE

Behaviour:
- Reset (async, rst_n=0): state=WAIT_VS; we=0, waddr=0, wdata=0, frame_done=0, busy=0; all counters, byte phase and first-byte latch cleared. Deasserting reset mid-frame returns to WAIT_VS and discards the partial frame.
- Inputs are sampled on the rising edge of clk; previous-cycle copies of vsync/href are kept for edge detection.
- States:
  WAIT_VS: wait for vsync=1 (this ignores any partial frame present at startup).
  WAIT_FRAME: on the vsync falling edge -> CAPTURE, with line counter y=0 and pixel counter x=0.
  CAPTURE: busy=1. On the vsync rising edge -> WAIT_FRAME and frame_done=1 for exactly one cycle. A short frame (fewer than SRC_V lines) still pulses frame_done.
- Byte pairing: the byte phase resets to 0 on every href rising edge. While href=1, phase 0 latches din as the high byte and phase 1 forms the RGB565 pixel {hi,din}. An odd trailing byte at the href fall is dropped.
- Pixel counting:
  - x increments after each completed pixel.
  - On the href falling edge, y increments and x returns to 0.
  - x saturates at SRC_H and y saturates at SRC_V; pixels beyond these limits are ignored.
- Keep rule: a pixel is stored iff x[SCALE_SHIFT-1:0]==0, y[SCALE_SHIFT-1:0]==0, (x>>SCALE_SHIFT)<IMAGE_SIZE_H and (y>>SCALE_SHIFT)<IMAGE_SIZE_V.
- Write timing: for a kept pixel, we=1 on the cycle after the phase-1 byte is sampled (1-cycle latency), with:
  - waddr = (y>>SCALE_SHIFT)*IMAGE_SIZE_H + (x>>SCALE_SHIFT), computed in 16 bits; the maximum is 19199, so it never wraps.
  - wdata = {p[15:12], p[10:7], p[4:1]}.
  - waddr and wdata hold their last value when we=0.
- Simultaneous events:
  - vsync rising edge while href=1: the frame end wins, and the in-flight pixel is dropped.
  - href falling edge on the same cycle as phase 1: the pixel completes and is written, then y increments.
- A short line (fewer than SRC_H pixels) produces no error. The next line starts at x=0.

Test Plan:
1. Reset, then vsync pulse, then 480 lines of 640 pixels with pixel value = {y[7:0],x[7:0]} -> exactly 19200 writes; first write waddr=0 with data from pixel (0,0); last write waddr=19199 from source pixel (636,476); frame_done pulses once at the vsync rise.
2. Pixel with bytes 0xF8,0x1F -> wdata=0xF0F; bytes 0x07,0xE0 -> wdata=0x0F0; we asserted exactly one cycle after the second byte.
3. Bench starts mid-frame (href toggling, vsync=0 at reset release) -> no writes until a full vsync high-then-low sequence; the first write after that is waddr=0.
4. Line with 700 pixel pairs and frame with 500 lines -> writes at waddr 0..19199 only; no waddr>=19200 ever; write count still 19200.
5. Odd byte count per line (1281 bytes) -> the trailing byte is ignored; the next line's first pixel pairs correctly (phase reset verified by wdata).
6. rst_n asserted during line 200 of a frame, then released -> outputs return to 0 immediately (async); no writes until the next complete vsync sequence; the following frame gives 19200 writes.

Source files
------------

// File: rtl/ov7670_frame_writer.sv
// ov7670_frame_writer
//   Captures the OV7670 RGB565 byte stream and decimates the source image by
//   2^SCALE_SHIFT in both axes. Each kept pixel is sent to the frame-RAM write
//   port as a linear address (row*IMAGE_SIZE_H + col) with RGB444 data.
// Ports
//   clk, rst_n       camera pclk; asynchronous active-low reset
//   vsync, href, din camera frame/line strobes and data byte
//   we/waddr/wdata   frame-RAM write port (one strobe per stored pixel)
//   frame_done       one-cycle pulse when a captured frame ends
//   busy             high while a frame is being captured
module ov7670_frame_writer #(
  parameter int IMAGE_SIZE_H = 160,
  parameter int IMAGE_SIZE_V = 120,
  parameter int SRC_H        = 640,
  parameter int SRC_V        = 480,
  parameter int SCALE_SHIFT  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  din,
  output logic        we,
  output logic [15:0] waddr,
  output logic [11:0] wdata,
  output logic        frame_done,
  output logic        busy
);

  localparam int XW = $clog2(SRC_H + 1);
  localparam int YW = $clog2(SRC_V + 1);
  localparam logic [XW-1:0] SRC_H_X = XW'(SRC_H);
  localparam logic [YW-1:0] SRC_V_Y = YW'(SRC_V);
  localparam logic [XW-1:0] IMG_H_X = XW'(IMAGE_SIZE_H);
  localparam logic [YW-1:0] IMG_V_Y = YW'(IMAGE_SIZE_V);
  localparam logic [XW-1:0] X_MASK  = XW'((1 << SCALE_SHIFT) - 1);
  localparam logic [YW-1:0] Y_MASK  = YW'((1 << SCALE_SHIFT) - 1);

  typedef enum logic [1:0] {WAIT_VS, WAIT_FRAME, CAPTURE} state_t;

  state_t          state, state_nxt;
  logic            vs_d, hr_d;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic            phase;
  // Only the high-byte bits that reach RGB444: {R[4:1], G[5:3]}
  logic [6:0]      hi;

  logic            vs_rise, vs_fall, hr_rise, hr_fall;
  logic            cap_start, cap_end, in_cap, ph_eff, pix_done;
  logic            x_ok, y_ok, keep;
  logic [15:0]     waddr_nxt;
  logic [11:0]     wdata_nxt;

  assign vs_rise = vsync & ~vs_d;
  assign vs_fall = ~vsync & vs_d;
  assign hr_rise = href & ~hr_d;
  assign hr_fall = ~href & hr_d;

  always_comb begin
    state_nxt = state;
    cap_start = 1'b0;
    cap_end   = 1'b0;
    busy      = 1'b0;
    case (state)
      WAIT_VS:    if (vsync) state_nxt = WAIT_FRAME;
      WAIT_FRAME: if (vs_fall) begin
                    state_nxt = CAPTURE;
                    cap_start = 1'b1;
                  end
      CAPTURE: begin
        busy = 1'b1;
        if (vs_rise) begin
          state_nxt = WAIT_FRAME;
          cap_end   = 1'b1;
        end
      end
      default:    state_nxt = WAIT_VS;
    endcase
  end

  // Frame end takes priority: a byte landing on the vsync rise is dropped.
  assign in_cap   = (state == CAPTURE) && !vs_rise;
  // A new line always starts with a high byte, whatever the last line left.
  assign ph_eff   = hr_rise ? 1'b0 : phase;
  assign pix_done = in_cap && href && ph_eff;
  assign x_ok     = x < SRC_H_X;
  assign y_ok     = y < SRC_V_Y;
  assign keep     = pix_done && x_ok && y_ok &&
                    ((x & X_MASK) == '0) && ((y & Y_MASK) == '0) &&
                    ((x >> SCALE_SHIFT) < IMG_H_X) &&
                    ((y >> SCALE_SHIFT) < IMG_V_Y);

  assign waddr_nxt = 16'(y >> SCALE_SHIFT) * 16'(IMAGE_SIZE_H) +
                     16'(x >> SCALE_SHIFT);
  // {hi,din} is RGB565; keep the top 4 bits of each channel.
  assign wdata_nxt = {hi[6:3], hi[2:0], din[7], din[4:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_VS;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d       <= 1'b0;
      hr_d       <= 1'b0;
      x          <= '0;
      y          <= '0;
      phase      <= 1'b0;
      hi         <= '0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      frame_done <= 1'b0;
    end else begin
      vs_d       <= vsync;
      hr_d       <= href;
      we         <= keep;
      frame_done <= cap_end;
      if (keep) begin
        waddr <= waddr_nxt;
        wdata <= wdata_nxt;
      end
      if (cap_start) begin
        x     <= '0;
        y     <= '0;
        phase <= 1'b0;
      end else if (in_cap) begin
        if (href) begin
          if (!ph_eff) begin
            hi    <= {din[7:4], din[2:0]};
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (x_ok) x <= x + 1'b1;
          end
        end else if (hr_fall) begin
          x <= '0;
          if (y_ok) y <= y + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_frame_writer.sv
// Bench for ov7670_frame_writer, run on a scaled geometry (64x48 source,
// 16x12 stored) so full frames fit a short simulation. A per-pixel model
// queues each expected write (address, RGB444 data, cycle) as stimulus is
// driven; one compare process checks every write and every missed write.
module tb_ov7670_frame_writer;
  localparam int IH = 16, IV = 12, SH = 64, SV = 48, SS = 2;
  localparam int NW = IH * IV;

  logic        clk = 1'b0, rst_n = 1'b0, vsync = 1'b0, href = 1'b0;
  logic [7:0]  din = '0;
  logic        we, frame_done, busy;
  logic [15:0] waddr;
  logic [11:0] wdata;

  ov7670_frame_writer #(.IMAGE_SIZE_H(IH), .IMAGE_SIZE_V(IV), .SRC_H(SH),
                        .SRC_V(SV), .SCALE_SHIFT(SS)) dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .href(href), .din(din),
    .we(we), .waddr(waddr), .wdata(wdata), .frame_done(frame_done),
    .busy(busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nerr = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct { int a; int d; int c; } wr_t;
  wr_t expq[$];
  bit  seen_vs = 0, cap = 0;
  int  ln = 0, px = 0, exp_fd = 0;

  function automatic int rgb444(logic [15:0] p);
    return int'({p[15:12], p[10:7], p[4:1]});
  endfunction

  function automatic logic [15:0] pat(int l, int i, logic [15:0] xr);
    logic [7:0] lb, ib;
    lb = 8'(l); ib = 8'(i);
    return {lb, ib} ^ xr;
  endfunction

  // ---------------- compare process ----------------
  int wr_cnt = 0, fd_cnt = 0, last_a = -1, last_d = -1;
  bit fd_prev = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) fd_cnt++;
      if (frame_done && fd_prev) chk("frame_done_width", 32'd2, 32'd1);
      fd_prev = frame_done;
      if (we) begin
        wr_cnt++;
        last_a = int'(waddr);
        last_d = int'(wdata);
        if (waddr >= 16'(NW)) chk("waddr_range", 32'(waddr), 32'(NW - 1));
        if (expq.size() == 0) chk("unexpected_we", 32'(we), 32'd0);
        else begin
          wr_t e;
          e = expq.pop_front();
          chk("waddr", 32'(waddr), 32'(e.a));
          chk("wdata", 32'(wdata), 32'(e.d));
          chk("we_cycle", 32'(cyc), 32'(e.c));
        end
      end else if (expq.size() > 0 && expq[0].c <= cyc) begin
        wr_t e;
        e = expq.pop_front();
        chk("missed_we", 32'(we), 32'd1);
      end
    end else fd_prev = 0;
  end

  // ---------------- stimulus ----------------
  task automatic tick(logic v, logic h, logic [7:0] d);
    vsync = v; href = h; din = d;
    @(posedge clk); #1;
  endtask

  task automatic pixel(logic [15:0] p);
    tick(1'b0, 1'b1, p[15:8]);
    tick(1'b0, 1'b1, p[7:0]);
    if (cap && ln < SV && px < SH && ln % (1 << SS) == 0 && px % (1 << SS) == 0
        && (px >> SS) < IH && (ln >> SS) < IV)
      expq.push_back('{a: (ln >> SS) * IH + (px >> SS), d: rgb444(p), c: cyc});
    px++;
  endtask

  task automatic line(int npix, bit odd, logic [15:0] xr);
    px = 0;
    for (int i = 0; i < npix; i++) pixel(pat(ln, i, xr));
    if (odd) tick(1'b0, 1'b1, 8'hAA);
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    ln++;
  endtask

  task automatic frame(int nl, int npix, bit odd, logic [15:0] xr);
    for (int l = 0; l < nl; l++) line(npix, odd, xr);
  endtask

  task automatic vs_pulse();
    tick(1'b1, 1'b0, 8'h00);
    if (cap) exp_fd++;
    cap = 0;
    seen_vs = 1;
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    if (seen_vs) begin cap = 1; ln = 0; end
    tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic end_checks(string nm, int wr0, int fd0, int exp_wr);
    chk({nm, "_writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    chk({nm, "_fd"}, 32'(fd_cnt - fd0), 32'd1);
    chk({nm, "_fd_model"}, 32'(fd_cnt), 32'(exp_fd));
    chk({nm, "_pending"}, 32'(expq.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wr0, fd0;
    // Start mid-frame: href toggling through reset and after release.
    for (int i = 0; i < 6; i++) tick(1'b0, 1'(i % 2), 8'(i));
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    frame(3, 20, 1'b0, 16'h0);
    chk("midframe_busy", 32'(busy), 32'd0);
    chk("midframe_writes", 32'(wr_cnt), 32'd0);

    // Full frame with pixel = {y,x}.
    vs_pulse();
    chk("capture_busy", 32'(busy), 32'd1);
    wr0 = wr_cnt; fd0 = fd_cnt;
    frame(SV, SH, 1'b0, 16'h0);
    vs_pulse();
    end_checks("full", wr0, fd0, NW);
    chk("full_last_addr", 32'(last_a), 32'd191);
    chk("full_last_data", 32'(last_d), 32'h28E);

    // Colour conversion and write latency; short frame still ends.
    wr0 = wr_cnt; fd0 = fd_cnt;
    px = 0;
    pixel(16'hF81F);
    @(negedge clk);
    chk("f81f_we", 32'(we), 32'd1);
    chk("f81f_wdata", 32'(wdata), 32'hF0F);
    chk("f81f_waddr", 32'(waddr), 32'd0);
    pixel(16'h1234);
    chk("we_one_cycle", 32'(we), 32'd0);
    pixel(16'h5678);
    pixel(16'h9ABC);
    pixel(16'h07E0);
    @(negedge clk);
    chk("07e0_we", 32'(we), 32'd1);
    chk("07e0_wdata", 32'(wdata), 32'h0F0);
    chk("07e0_waddr", 32'(waddr), 32'd1);
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    ln++;
    vs_pulse();
    end_checks("short", wr0, fd0, 2);

    // Oversized lines and frame: writes stay inside the image.
    wr0 = wr_cnt; fd0 = fd_cnt;
    frame(SV + 2, SH + 6, 1'b0, 16'h3C5A);
    vs_pulse();
    end_checks("oversize", wr0, fd0, NW);

    // Odd byte count per line: trailing byte dropped, next line re-pairs.
    wr0 = wr_cnt; fd0 = fd_cnt;
    frame(SV, SH, 1'b1, 16'hA5C3);
    vs_pulse();
    end_checks("odd", wr0, fd0, NW);
    chk("odd_last_data", 32'(last_d), 32'h83F);

    // Reset in the middle of line 20 of a frame.
    frame(20, SH, 1'b0, 16'h0);
    px = 0;
    for (int i = 0; i < 10; i++) pixel(pat(ln, i, 16'h0));
    tick(1'b0, 1'b1, 8'h55);
    chk("pre_rst_waddr", 32'(last_a), 32'd82);
    rst_n = 1'b0;
    #1;
    chk("async_rst_we", 32'(we), 32'd0);
    chk("async_rst_waddr", 32'(waddr), 32'd0);
    chk("async_rst_wdata", 32'(wdata), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    cap = 0; seen_vs = 0;
    chk("rst_pending", 32'(expq.size()), 32'd0);
    tick(1'b0, 1'b1, 8'h11);
    tick(1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    wr0 = wr_cnt;
    frame(2, SH, 1'b0, 16'h0);
    chk("post_rst_writes", 32'(wr_cnt - wr0), 32'd0);
    vs_pulse();
    wr0 = wr_cnt; fd0 = fd_cnt;
    frame(SV, SH, 1'b0, 16'h0F0F);
    vs_pulse();
    end_checks("after_rst", wr0, fd0, NW);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
